sweep_decoder: RTL

Parametrised, registered successor to the 5-to-32 combinational decoder. It produces a one-hot output of configurable width in four modes:

- direct decode of `sel`;
- single sweep across outputs;
- continuous looping sweep;
- hold.

Each sweep step lasts a programmable dwell time. It drives row/chip-select lines and LED scan chains in the lab designs, where the output must be glitch-free, so all outputs are registered.

---
 rtl/sweep_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sweep_decoder.sv
// Registered one-hot decoder with direct, single-sweep, looping-sweep and hold modes.
// Sweep steps last DWELL cycles each; every output comes straight from a flop.
module sweep_decoder #(
    parameter int SEL_W = 5,
    parameter int OUT_W = 32,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             range_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_ONCE   = 2'b01;
    localparam logic [1:0] M_LOOP   = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    // One extra bit so OUT_W == 2**SEL_W stays representable.
    localparam logic [SEL_W:0]   OUT_LIM = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W - 1);
    localparam logic [15:0]      DW_LAST = 16'(DWELL - 1);

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             loop_q, loop_d;
    logic             done_q, done_d;
    logic             rerr_q, rerr_d;

    logic             sel_ok;
    logic [OUT_W-1:0] sel_hot;

    assign sel_ok  = {1'b0, sel} < OUT_LIM;
    assign sel_hot = OUT_W'(1) << sel;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        rerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!enable) begin
                    out_d = '0;
                end else begin
                    unique case (mode)
                        M_DIRECT: begin
                            if (sel_ok) begin
                                out_d = sel_hot;
                                idx_d = sel;
                            end else begin
                                out_d  = '0;
                                rerr_d = 1'b1;
                            end
                        end
                        M_HOLD: begin
                        end
                        M_ONCE, M_LOOP: begin
                            if (start) begin
                                if (sel_ok) begin
                                    out_d   = sel_hot;
                                    idx_d   = sel;
                                    cnt_d   = '0;
                                    loop_d  = (mode == M_LOOP);
                                    state_d = RUN;
                                end else begin
                                    rerr_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                if (!enable) begin
                    out_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DW_LAST) begin
                    cnt_d = '0;
                    if (idx_q != LAST) begin
                        idx_d = idx_q + SEL_W'(1);
                        out_d = out_q << 1;
                    end else if (loop_q) begin
                        idx_d = '0;
                        out_d = OUT_W'(1);
                    end else begin
                        out_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            rerr_q  <= rerr_d;
        end
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign range_err = rerr_q;

endmodule
